// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract unit: FSM state
// encoding, operation select codes and the default operand width.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEFAULT_WIDTH = 6;

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// Single-bit full adder, reused once per clock by the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;

    // Propagate / generate form of the full adder.
    always_comb begin
        w_p  = a ^ b;
        s    = w_p ^ cin;
        cout = (a & b) | (cin & w_p);
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement add/subtract with valid/ready on both sides.
// One operand bit is processed per clock through a single fa_cell; the
// result is assembled LSB-first in a shift register.
// Optional build macro: SERIAL_ADDSUB_CARRY_OUT_EN adds the carry_out port
// (unsigned carry for add, not-borrow for subtract), latched with sum.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | in_ready=1, waiting for in_valid to capture operands
//   RUN   | one bit per clock through fa_cell, WIDTH cycles
//   DONE  | out_valid=1, result held until out_ready
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
`ifdef SERIAL_ADDSUB_CARRY_OUT_EN
   ,output logic             carry_out
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CW-1:0]    r_bit_cnt;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_s;
    logic             w_cout;

    // The one full-adder cell shared by every bit position.
    fa_cell u_fa (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    // Handshake qualifiers derived from the registered state only.
    always_comb begin
        w_accept = (r_state == IDLE) && in_valid;
        w_last   = (r_state == RUN) && (r_bit_cnt == LAST_BIT);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; ready/valid never see in_valid/out_ready.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture and serial shift datapath. Subtraction is folded into
    // capture: invert y and seed the carry with 1, so RUN only ever adds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_sum_sr  <= '0;
            r_carry   <= 1'b0;
            r_bit_cnt <= '0;
            r_ovf     <= 1'b0;
        end else if (w_accept) begin
            r_a_sr    <= x;
            r_b_sr    <= y ^ {WIDTH{sel}};
            r_carry   <= (sel == OP_SUB);
            r_bit_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a_sr    <= r_a_sr >> 1;
            r_b_sr    <= r_b_sr >> 1;
            r_sum_sr  <= {w_s, r_sum_sr[WIDTH-1:1]};
            r_carry   <= w_cout;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_last) begin
                // Signed overflow: carry into the sign bit differs from carry out.
                r_ovf <= r_carry ^ w_cout;
            end
        end
    end

`ifdef SERIAL_ADDSUB_CARRY_OUT_EN
    logic r_cout;

    // Final carry of the MSB, captured on the same edge as the last sum bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cout <= 1'b0;
        end else if (w_last) begin
            r_cout <= w_cout;
        end
    end

    assign carry_out = r_cout;
`endif

    assign sum      = r_sum_sr;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed cases from the test plan
// plus randomized operations, all judged by an arithmetic reference model.
module tb_serial_addsub;

    localparam int W = 6;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         overflow;
`ifdef SERIAL_ADDSUB_CARRY_OUT_EN
    logic         carry_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .overflow  (overflow)
`ifdef SERIAL_ADDSUB_CARRY_OUT_EN
       ,.carry_out (carry_out)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference arithmetic on plain integers.
    function automatic int model_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return s ? (sa - sb) : (sa + sb);
    endfunction

    function automatic logic [W-1:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int r;
        r = model_result(a, b, s);
        return r[W-1:0];
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int r;
        r = model_result(a, b, s);
        return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
    endfunction

    function automatic logic model_co(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        if (s) return int'(a) >= int'(b);
        return (int'(a) + int'(b)) >= (1 << W);
    endfunction

    // Cycle-level expectation: 0 idle, 1 computing, 2 result presented.
    int           m_phase = 0;
    int           m_left  = 0;
    logic [W-1:0] m_sum;
    logic         m_ovf;
    logic         m_co;

    // Compare process: every falling edge, check outputs against the model,
    // then advance the model to what the next rising edge should produce.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_sum", sum, 0);
            chk("rst_ovf", overflow, 0);
`ifdef SERIAL_ADDSUB_CARRY_OUT_EN
            chk("rst_carry_out", carry_out, 0);
`endif
            m_phase = 0;
        end else begin
            chk("in_ready", in_ready, (m_phase == 0));
            chk("out_valid", out_valid, (m_phase == 2));
            if (m_phase == 2) begin
                chk("sum", sum, m_sum);
                chk("overflow", overflow, m_ovf);
`ifdef SERIAL_ADDSUB_CARRY_OUT_EN
                chk("carry_out", carry_out, m_co);
`endif
            end
            case (m_phase)
                0: if (in_valid) begin
                    m_sum   = model_sum(x, y, sel);
                    m_ovf   = model_ovf(x, y, sel);
                    m_co    = model_co(x, y, sel);
                    m_left  = W;
                    m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    // One operation, called at posedge+#1. hold = cycles of out_ready low in DONE.
    task automatic run_op(input logic [W-1:0] ax, input logic [W-1:0] ay, input logic asel,
                          input int hold, output logic [W-1:0] rs, output logic rovf,
                          output int lat);
        int guard;
        logic [W-1:0] es;
        logic eo;
        es = model_sum(ax, ay, asel);
        eo = model_ovf(ax, ay, asel);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("wait_in_ready", in_ready, 1);
        x = ax; y = ay; sel = asel; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = W'($urandom); y = W'($urandom); sel = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 3 * W) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_seen", out_valid, 1);
        rs = sum;
        rovf = overflow;
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                in_valid = 1'b1;
                x = W'($urandom); y = W'($urandom); sel = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_sum", sum, es);
            chk("hold_ovf", overflow, eo);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ready_back", in_ready, 1);
        chk("valid_drop", out_valid, 0);
    endtask

    logic [W-1:0] r_s;
    logic         r_o;
    int           lat;

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int acc [3];
        int found;
        int guard;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; sel = 1'b0;

        // Pin the reference model with hand-computed values.
        chk("model_sub_1_m1", model_sum(6'd1, 6'd63, 1'b1), 2);
        chk("model_ovf_31p1", model_ovf(6'd31, 6'd1, 1'b0), 1);
        chk("model_sub_m32_1", model_sum(6'd32, 6'd1, 1'b1), 31);
        chk("model_ovf_m32_1", model_ovf(6'd32, 6'd1, 1'b1), 1);
        chk("model_co_63p1", model_co(6'd63, 6'd1, 1'b0), 1);

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_sum", sum, 0);

        run_op(6'b000001, 6'b111111, 1'b1, 1, r_s, r_o, lat);
        chk("sub_sum", r_s, 6'b000010);
        chk("sub_ovf", r_o, 0);
        chk("latency", lat + 1, 7);

        run_op(6'b000011, 6'b000010, 1'b0, 0, r_s, r_o, lat);
        chk("add_sum", r_s, 6'b000101);
        chk("add_ovf", r_o, 0);

        run_op(6'b011111, 6'b000001, 1'b0, 0, r_s, r_o, lat);
        chk("addovf_sum", r_s, 6'b100000);
        chk("addovf_ovf", r_o, 1);

        run_op(6'b100000, 6'b000001, 1'b1, 2, r_s, r_o, lat);
        chk("subovf_sum", r_s, 6'b011111);
        chk("subovf_ovf", r_o, 1);

        // Backpressure: 5 - 9 = -4, held for 5 cycles with a stray in_valid.
        run_op(6'd5, 6'd9, 1'b1, 5, r_s, r_o, lat);
        chk("bp_sum", r_s, 6'd60);
        chk("bp_ovf", r_o, 0);

`ifdef SERIAL_ADDSUB_CARRY_OUT_EN
        run_op(6'b111111, 6'b000001, 1'b0, 0, r_s, r_o, lat);
        chk("co_sum", r_s, 6'b000000);
        chk("co_ovf", r_o, 0);
        chk("co_carry", carry_out, 1);
`endif

        // Reset during the third RUN cycle.
        x = 6'd17; y = 6'd9; sel = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(6'b000011, 6'b000010, 1'b0, 0, r_s, r_o, lat);
        chk("after_rst_sum", r_s, 6'b000101);

        // Throughput with in_valid and out_ready both held high.
        x = 6'd7; y = 6'd30; sel = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 40 && found < 3; c++) begin
            if (in_ready) begin
                acc[found] = c;
                found++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("tput_accepts", found, 3);
        if (found == 3) begin
            chk("tput_gap1", acc[1] - acc[0], 8);
            chk("tput_gap2", acc[2] - acc[1], 8);
        end
        guard = 0;
        while (!in_ready && guard < 30) begin
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b0;
        chk("tput_idle", in_ready, 1);

        // Randomized operations; the compare process judges every cycle.
        for (int k = 0; k < 200; k++) begin
            logic [W-1:0] rx;
            logic [W-1:0] ry;
            logic         rsl;
            rx  = W'($urandom);
            ry  = W'($urandom);
            rsl = 1'($urandom);
            run_op(rx, ry, rsl, $urandom_range(0, 3), r_s, r_o, lat);
            chk("rand_latency", lat, W);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
